// File: rtl/mycpu_div_if.sv
// mycpu_div_if: operand/result handshake bundle between the execute stage and the iterative divider.
//   master (pipeline): drives in_valid, div_signed, A, B, cancel, out_ready
//   slave  (divider) : drives in_ready, out_valid, quotient, remainder
interface mycpu_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  div_signed;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  cancel;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport master (
        output in_valid, div_signed, A, B, cancel, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, div_signed, A, B, cancel, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/mycpu_div.sv
// mycpu_div: radix-2 restoring divider for MIPS DIV/DIVU, 32 iterations plus one fix-up cycle.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : mycpu_div_if.slave -- operand handshake (in_valid/in_ready/div_signed/A/B),
//           abort (cancel), result handshake (out_valid/out_ready/quotient/remainder)
module mycpu_div #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    mycpu_div_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvd_q, dvd_d;
    logic [W-1:0] dsor_q, dsor_d;
    logic         negq_q, negq_d;
    logic         negr_q, negr_d;
    logic         dz_q, dz_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] remd_q, remd_d;
    logic [W:0]   trial;

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remd_q;

    // Trial subtract of the shifted-in partial remainder; trial[W] is the borrow.
    assign trial = {rem_q, dvd_q[W-1]} - {1'b0, dsor_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsor_d  = dsor_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        if (bus.cancel) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.in_valid) begin
                state_d = BUSY;
                cnt_d   = '0;
                rem_d   = '0;
                dvd_d   = (bus.div_signed && bus.A[W-1]) ? -bus.A : bus.A;
                dsor_d  = (bus.div_signed && bus.B[W-1]) ? -bus.B : bus.B;
                negq_d  = bus.div_signed && (bus.A[W-1] ^ bus.B[W-1]);
                negr_d  = bus.div_signed && bus.A[W-1];
                dz_d    = bus.B == '0;
            end
        end else if (state_q == BUSY) begin
            if (cnt_q == 6'(W)) begin
                state_d = DONE;
                // With a zero divisor every trial succeeds, so the remainder path already
                // reconstructs the original A; only the quotient needs forcing.
                quot_d  = dz_q ? '1 : (negq_q ? -dvd_q : dvd_q);
                remd_d  = negr_q ? -rem_q : rem_q;
            end else begin
                cnt_d = cnt_q + 6'd1;
                rem_d = trial[W] ? {rem_q[W-2:0], dvd_q[W-1]} : trial[W-1:0];
                dvd_d = {dvd_q[W-2:0], ~trial[W]};
            end
        end else if (state_q == DONE) begin
            state_d = bus.out_ready ? IDLE : DONE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsor_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsor_q  <= dsor_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
        end
    end
endmodule
